// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misalign_err,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Upper address bits wrap within memory.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (req_size == 2'b00): req_err = 1'b0;
      (req_size == 2'b01): req_err = req_addr[0];
      (req_size == 2'b10): req_err = |req_addr[1:0];
      default:             req_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel  = mem_rd_data[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? mem_rd_data[31:16]
                          : mem_rd_data[15:0];
    load_data = mem_rd_data;
    unique case (1'b1)
      (size_q == 2'b00):
        load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      (size_q == 2'b01):
        load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
      default:
        load_data = mem_rd_data;
    endcase
  end

  always_comb begin
    merged = mem_rd_data;
    unique case (1'b1)
      (size_q == 2'b00):
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      (size_q == 2'b01):
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default:
        merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      misalign_err <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_wr_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= req_addr[ADDR_W+1:2];
            req_ready <= 1'b0;
            if (req_err) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_rdata   <= '0;
              misalign_err <= 1'b1;
            end else if (req_we && req_size == 2'b10) begin
              state       <= WRITE;
              mem_wr_en   <= 1'b1;
              mem_wr_data <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state       <= WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_data <= merged;
          end else begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_rdata   <= load_data;
            misalign_err <= 1'b0;
          end
        end
        WRITE: begin
          state        <= RESP;
          resp_valid   <= 1'b1;
          resp_rdata   <= '0;
          misalign_err <= 1'b0;
        end
        RESP: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          misalign_err <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset abort,
// back-to-back loads and random ops against a reference model.
module tb_load_store_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          misalign_err;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .misalign_err(misalign_err),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255] = '{default: 32'h0};
  assign mem_rd_data = ram[mem_addr];
  always @(posedge clk)
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;

  logic [31:0] ref_mem [0:255] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: spec rules as plain arithmetic on a word array.
  task automatic ref_op(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wrs);
    int unsigned idx, sh, mask, v;
    idx = (addr / 4) % 256;
    sh = (addr % 4) * 8;
    mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFFFFFF;
    err = (size == 3) || (size == 1 && addr % 2 != 0) ||
          (size == 2 && addr % 4 != 0);
    rdata = 0;
    lat = 1;
    wrs = 0;
    if (!err && we) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
      lat = (size == 2) ? 2 : 3;
      wrs = 1;
    end else if (!err) begin
      v = (ref_mem[idx] >> sh) & mask;
      if (!uns && size == 0 && v >= 128) v = v - 256;
      if (!uns && size == 1 && v >= 32768) v = v - 65536;
      rdata = v;
      lat = 2;
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after it is idle again.
  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wrs,
                        output logic [AW-1:0] a_seen);
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    wrs = 0;
    rdata = 32'hDEADDEAD;
    err = 1'b0;
    a_seen = mem_addr;
    for (int c = 1; c <= 8; c++) begin
      if (mem_wr_en) wrs++;
      if (resp_valid) begin
        lat = c;
        rdata = resp_rdata;
        err = misalign_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic we,
                     input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic use_tbl, input logic [31:0] t_rdata,
                     input logic t_err, input int t_lat);
    logic [31:0] m_rdata, d_rdata;
    logic m_err, d_err;
    int m_lat, m_wrs, d_lat, d_wrs;
    logic [AW-1:0] a_seen;
    int unsigned idx;
    idx = (addr / 4) % 256;
    ref_op(we, size, uns, addr, wdata, m_rdata, m_err, m_lat, m_wrs);
    do_req(we, size, uns, addr, wdata, d_rdata, d_err, d_lat, d_wrs, a_seen);
    if (use_tbl) begin
      chk({name, " rdata"}, d_rdata, t_rdata);
      chk({name, " err"}, 32'(d_err), 32'(t_err));
      chk({name, " latency"}, 32'(d_lat), 32'(t_lat));
    end else begin
      chk({name, " rdata"}, d_rdata, m_rdata);
      chk({name, " err"}, 32'(d_err), 32'(m_err));
      chk({name, " latency"}, 32'(d_lat), 32'(m_lat));
    end
    chk({name, " wr pulses"}, 32'(d_wrs), 32'(m_wrs));
    if (!m_err) chk({name, " mem_addr"}, 32'(a_seen), idx);
    chk({name, " ram word"}, ram[idx], ref_mem[idx]);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e_rd;
    logic e_err;
    int e_lat, e_wrs, acc, got, last_acc;
    logic rdy;
    logic [31:0] exp_q[$];
    logic [31:0] b_addr [4];
    logic [1:0]  b_size [4];
    logic        b_uns  [4];

    #12;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset misalign_err", 32'(misalign_err), 0);
    chk("reset mem_wr_en", 32'(mem_wr_en), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_wr_data", mem_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back('{1, 2'd2, 0, 32'h14, 32'h0000007B, 32'h0, 0, 2});
    vecs.push_back('{0, 2'd2, 0, 32'h14, 32'h0, 32'h0000007B, 0, 2});
    vecs.push_back('{1, 2'd2, 0, 32'h14, 32'h11223344, 32'h0, 0, 2});
    vecs.push_back('{1, 2'd0, 0, 32'h16, 32'h000000AA, 32'h0, 0, 3});
    vecs.push_back('{0, 2'd2, 0, 32'h14, 32'h0, 32'h11AA3344, 0, 2});
    vecs.push_back('{0, 2'd0, 0, 32'h16, 32'h0, 32'hFFFFFFAA, 0, 2});
    vecs.push_back('{0, 2'd0, 1, 32'h16, 32'h0, 32'h000000AA, 0, 2});
    vecs.push_back('{1, 2'd1, 0, 32'h12, 32'h0000BEEF, 32'h0, 0, 3});
    vecs.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'hBEEF0000, 0, 2});
    vecs.push_back('{0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFFBEEF, 0, 2});
    vecs.push_back('{0, 2'd1, 1, 32'h12, 32'h0, 32'h0000BEEF, 0, 2});
    vecs.push_back('{0, 2'd1, 0, 32'h13, 32'h0, 32'h0, 1, 1});
    vecs.push_back('{1, 2'd2, 0, 32'h06, 32'h12345678, 32'h0, 1, 1});
    vecs.push_back('{0, 2'd3, 0, 32'h14, 32'h0, 32'h0, 1, 1});
    vecs.push_back('{1, 2'd3, 0, 32'h14, 32'hFFFFFFFF, 32'h0, 1, 1});
    vecs.push_back('{0, 2'd2, 0, 32'h14, 32'h0, 32'h11AA3344, 0, 2});
    vecs.push_back('{1, 2'd0, 0, 32'h417, 32'hFFFFFF5A, 32'h0, 0, 3});
    vecs.push_back('{0, 2'd2, 0, 32'h14, 32'h0, 32'h5AAA3344, 0, 2});

    for (int i = 0; i < vecs.size(); i++)
      run($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
          vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].rdata,
          vecs[i].err, vecs[i].lat);

    // Reset while a sub-word store sits in READ.
    req_we = 1'b1;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h15;
    req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rmw ready low", 32'(req_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("abort req_ready", 32'(req_ready), 1);
    chk("abort resp_valid", 32'(resp_valid), 0);
    chk("abort resp_rdata", resp_rdata, 0);
    chk("abort mem_wr_en", 32'(mem_wr_en), 0);
    chk("abort mem_addr", 32'(mem_addr), 0);
    chk("abort mem_wr_data", mem_wr_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort word5", ram[5], ref_mem[5]);
    chk("abort ready after", 32'(req_ready), 1);

    // Back-to-back loads with req_valid held high.
    b_addr = '{32'h10, 32'h14, 32'h16, 32'h12};
    b_size = '{2'd2, 2'd2, 2'd0, 2'd1};
    b_uns  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ref_op(1'b0, b_size[i], b_uns[i], b_addr[i], 32'h0,
             e_rd, e_err, e_lat, e_wrs);
      exp_q.push_back(e_rd);
    end
    acc = 0;
    got = 0;
    last_acc = 0;
    req_we = 1'b0;
    req_size = b_size[0];
    req_unsigned = b_uns[0];
    req_addr = b_addr[0];
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      rdy = req_ready;
      if (resp_valid) begin
        chk($sformatf("b2b resp%0d", got), resp_rdata, exp_q[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (rdy && acc < 4) begin
        acc++;
        chk("b2b ready drop", 32'(req_ready), 0);
        if (acc > 1) chk("b2b accept gap", 32'(cyc - last_acc), 3);
        last_acc = cyc;
        if (acc < 4) begin
          req_size = b_size[acc];
          req_unsigned = b_uns[acc];
          req_addr = b_addr[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b accepts", 32'(acc), 4);
    chk("b2b responses", 32'(got), 4);
    @(posedge clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 10);
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, 1'b0, 32'h0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
